// File: rtl/bcd_scan_counter.sv
// -----------------------------------------------------------------------------
// bcd_scan_counter
//
// Two-digit BCD up/down counter (00..99) with a prescaled count tick,
// synchronous saturating load and a registered wrap pulse. The two digits are
// time-multiplexed onto a 7-segment bus with a one-hot digit select.
//
// Parameters
//   PRESCALE  clk cycles per count tick while en=1 (1..65535)
//   SCAN_DIV  clk cycles each digit is shown before dig_sel rotates (1..65535)
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   en         in   count enable, gates the prescaler
//   up         in   1 = increment, 0 = decrement (sampled on the tick cycle)
//   load       in   synchronous load strobe, wins over a coincident tick
//   load_val   in   BCD load value {tens, units}; nibbles > 9 load as 9
//   count_bcd  out  registered BCD count {tens, units}
//   wrap       out  one-cycle pulse aligned with a 99->00 or 00->99 count
//   seg        out  segment pattern {g,f,e,d,c,b,a}, active-high, combinational
//   dig_sel    out  one-hot digit select: 01 = units, 10 = tens
// -----------------------------------------------------------------------------
module bcd_scan_counter #(
  parameter int PRESCALE = 4,
  parameter int SCAN_DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] count_bcd,
  output logic       wrap,
  output logic [6:0] seg,
  output logic [1:0] dig_sel
);

  localparam logic [15:0] PRE_TC  = 16'(PRESCALE - 1);
  localparam logic [15:0] SCAN_TC = 16'(SCAN_DIV - 1);

  logic [15:0] presc_q, presc_d;
  logic [15:0] scan_q,  scan_d;
  logic [3:0]  tens_q,  tens_d;
  logic [3:0]  units_q, units_d;
  logic        wrap_q,  wrap_d;
  logic [1:0]  dig_q,   dig_d;
  logic        tick;

  // Saturate an out-of-range nibble to 9 so count_bcd is always valid BCD.
  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic [6:0] decode7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  assign tick = en && (presc_q == PRE_TC);

  // Counter / prescaler / wrap next state.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    presc_d = presc_q;
    tens_d  = tens_q;
    units_d = units_q;
    wrap_d  = 1'b0;

    if (load) begin
      // Load discards any tick landing on the same edge.
      tens_d  = clamp_bcd(load_val[7:4]);
      units_d = clamp_bcd(load_val[3:0]);
      presc_d = '0;
    end else if (tick) begin
      presc_d = '0;
      if (up) begin
        if (units_q == 4'd9) begin
          units_d = 4'd0;
          if (tens_q == 4'd9) begin
            tens_d = 4'd0;
            wrap_d = 1'b1;
          end else begin
            tens_d = tens_q + 4'd1;
          end
        end else begin
          units_d = units_q + 4'd1;
        end
      end else begin
        if (units_q == 4'd0) begin
          units_d = 4'd9;
          if (tens_q == 4'd0) begin
            tens_d = 4'd9;
            wrap_d = 1'b1;
          end else begin
            tens_d = tens_q - 4'd1;
          end
        end else begin
          units_d = units_q - 4'd1;
        end
      end
    end else if (en) begin
      presc_d = presc_q + 16'd1;
    end
  end

  // Free-running scan divider; rotation keeps dig_sel one-hot by construction.
  always_comb begin
    scan_d = scan_q + 16'd1;
    dig_d  = dig_q;
    if (scan_q == SCAN_TC) begin
      scan_d = '0;
      dig_d  = {dig_q[0], dig_q[1]};
    end
  end

  // NOTE: reset is asynchronous, so it sits in the sensitivity list and acts
  // without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      scan_q  <= '0;
      tens_q  <= '0;
      units_q <= '0;
      wrap_q  <= 1'b0;
      dig_q   <= 2'b01;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      presc_q <= presc_d;
      scan_q  <= scan_d;
      tens_q  <= tens_d;
      units_q <= units_d;
      wrap_q  <= wrap_d;
      dig_q   <= dig_d;
    end
  end

  assign count_bcd = {tens_q, units_q};
  assign wrap      = wrap_q;
  assign dig_sel   = dig_q;
  assign seg       = decode7(dig_q[1] ? tens_q : units_q);

endmodule

// File: tb/tb_bcd_scan_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_scan_counter
//
// Directed bench for bcd_scan_counter. The main instance uses PRESCALE=4,
// SCAN_DIV=2; a second instance with PRESCALE=1 shares the same inputs and is
// only checked in its own section. Inputs change 1 ns after a rising edge and
// outputs are checked at that same point, well clear of the next edge.
// -----------------------------------------------------------------------------
module tb_bcd_scan_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       up;
  logic       load;
  logic [7:0] load_val;

  logic [7:0] count_bcd, count_bcd1;
  logic       wrap, wrap1;
  logic [6:0] seg, seg1;
  logic [1:0] dig_sel, dig_sel1;

  logic [6:0] seg_reg;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bcd_scan_counter #(.PRESCALE(4), .SCAN_DIV(2)) dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .count_bcd(count_bcd), .wrap(wrap),
    .seg(seg), .dig_sel(dig_sel)
  );

  bcd_scan_counter #(.PRESCALE(1), .SCAN_DIV(2)) dut1 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .count_bcd(count_bcd1), .wrap(wrap1),
    .seg(seg1), .dig_sel(dig_sel1)
  );

  // Stand-in for the downstream display register fed by seg.
  always @(posedge clk) seg_reg <= seg;

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    load     = 1'b1;
    load_val = v;
    cycles(1);
    load     = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 8'h00;

    // Power-on reset state
    cycles(1);
    check("rst_count", count_bcd, 8'h00);
    check("rst_dig",   {6'd0, dig_sel}, 8'h01);
    check("rst_seg",   {1'b0, seg}, 8'h3F);
    check("rst_wrap",  {7'd0, wrap}, 8'h00);
    reset = 1'b0; en = 1'b1;
    cycles(3);
    check("first_tick_early", count_bcd, 8'h00);
    cycles(1);
    check("first_tick", count_bcd, 8'h01);

    // Reset mid-count: takes effect immediately, held for 20 ns
    cycles(6);
    check("pre_reset_count", count_bcd, 8'h02);
    reset = 1'b1;
    #1;
    check("async_rst_count", count_bcd, 8'h00);
    check("async_rst_dig",   {6'd0, dig_sel}, 8'h01);
    check("async_rst_seg",   {1'b0, seg}, 8'h3F);
    check("async_rst_wrap",  {7'd0, wrap}, 8'h00);
    #19;
    reset = 1'b0;
    cycles(4);
    check("post_rst_4", count_bcd, 8'h01);
    cycles(4);
    check("post_rst_8", count_bcd, 8'h02);

    // Carry and wrap going up
    do_load(8'h98);
    check("load_98", count_bcd, 8'h98);
    cycles(4);
    check("up_99", count_bcd, 8'h99);
    check("up_99_wrap", {7'd0, wrap}, 8'h00);
    cycles(3);
    check("up_99_hold", count_bcd, 8'h99);
    cycles(1);
    check("up_00", count_bcd, 8'h00);
    check("up_wrap_hi", {7'd0, wrap}, 8'h01);
    cycles(1);
    check("up_wrap_lo", {7'd0, wrap}, 8'h00);
    do_load(8'h09);
    cycles(4);
    check("carry_10", count_bcd, 8'h10);
    check("carry_no_wrap", {7'd0, wrap}, 8'h00);

    // Borrow and wrap going down
    up = 1'b0;
    do_load(8'h10);
    cycles(4);
    check("borrow_09", count_bcd, 8'h09);
    do_load(8'h00);
    cycles(4);
    check("down_99", count_bcd, 8'h99);
    check("down_wrap_hi", {7'd0, wrap}, 8'h01);
    cycles(1);
    check("down_wrap_lo", {7'd0, wrap}, 8'h00);
    // Prescaler now at 1; freeze for 10 cycles, then 2 more enabled cycles
    // reach its terminal count and the third produces the tick.
    en = 1'b0;
    cycles(10);
    check("frozen", count_bcd, 8'h99);
    en = 1'b1;
    cycles(2);
    check("held_presc_early", count_bcd, 8'h99);
    cycles(1);
    check("held_presc_tick", count_bcd, 8'h98);

    // Load on the tick cycle wins and clears the prescaler
    up = 1'b1;
    cycles(3);
    check("pre_tick", count_bcd, 8'h98);
    do_load(8'h57);
    check("load_prio", count_bcd, 8'h57);
    cycles(3);
    check("load_presc_clr", count_bcd, 8'h57);
    cycles(1);
    check("after_load_tick", count_bcd, 8'h58);
    do_load(8'hAF);
    check("clamp_AF", count_bcd, 8'h99);
    en = 1'b0;
    do_load(8'hA3);
    check("clamp_A3_en0", count_bcd, 8'h93);
    do_load(8'h3C);
    check("clamp_3C_en0", count_bcd, 8'h39);

    // Scan and decode: restart the scan phase with a reset, then load 42
    reset = 1'b1;
    #10;
    reset = 1'b0;
    do_load(8'h42);
    check("scan_cnt", count_bcd, 8'h42);
    check("scan0_dig", {6'd0, dig_sel}, 8'h01);
    check("scan0_seg", {1'b0, seg}, 8'h5B);
    cycles(1);
    check("scan1_dig", {6'd0, dig_sel}, 8'h02);
    check("scan1_seg", {1'b0, seg}, 8'h66);
    check("scan1_reg", {1'b0, seg_reg}, 8'h5B);
    cycles(1);
    check("scan2_dig", {6'd0, dig_sel}, 8'h02);
    check("scan2_seg", {1'b0, seg}, 8'h66);
    check("scan2_reg", {1'b0, seg_reg}, 8'h66);
    cycles(1);
    check("scan3_dig", {6'd0, dig_sel}, 8'h01);
    check("scan3_seg", {1'b0, seg}, 8'h5B);
    check("scan3_reg", {1'b0, seg_reg}, 8'h66);
    cycles(1);
    check("scan4_dig", {6'd0, dig_sel}, 8'h01);
    check("scan4_reg", {1'b0, seg_reg}, 8'h5B);

    // PRESCALE=1 instance: counts every enabled cycle
    up = 1'b1;
    do_load(8'h98);
    check("p1_load", count_bcd1, 8'h98);
    en = 1'b1;
    cycles(1);
    check("p1_99", count_bcd1, 8'h99);
    check("p1_99_wrap", {7'd0, wrap1}, 8'h00);
    cycles(1);
    check("p1_00", count_bcd1, 8'h00);
    check("p1_wrap_hi", {7'd0, wrap1}, 8'h01);
    cycles(1);
    check("p1_01", count_bcd1, 8'h01);
    check("p1_wrap_lo", {7'd0, wrap1}, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
